fetch_ctrl: RTL

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch sequencer for a small ROM-based processor.
// Walks the program counter through the instruction ROM, follows taken
// branches, stops on the halt encoding and reports run/done status.
// Optional cycle counter: define FETCH_CTRL_CYCLE_CNT_EN to build it;
// without it CycleCount is tied to zero.
module fetch_ctrl #(
  parameter int unsigned       PC_W    = 10,
  parameter int unsigned       INST_W  = 9,
  parameter logic [INST_W-1:0] HALT_OP = 9'b111_111_111
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Stall,
  input  logic              JmpEq,
  input  logic              JmpNe,
  input  logic              Zero,
  input  logic [PC_W-1:0]   DestAddr,
  input  logic [INST_W-1:0] InstIn,
  output logic [PC_W-1:0]   ProgCtr,
  output logic              InstValid,
  output logic              Busy,
  output logic              Done,
  output logic [15:0]       CycleCount
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } fetchState_t;

  fetchState_t     state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            done_q, done_d;

  logic isHalt;
  logic branchTaken;
  logic startRun;

  // Decode of the current instruction word and branch condition.
  always_comb begin
    isHalt      = (InstIn == HALT_OP);
    branchTaken = (JmpEq & Zero) | (JmpNe & ~Zero);
    startRun    = Start & (state_q != StRun);
  end

  // Next-state logic: halt outranks branches, stall freezes everything but
  // the cycle counter, and a (re)start always begins at address zero.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    done_d  = done_q;
    unique case (state_q)
      StIdle: begin
        if (Start) begin
          state_d = StRun;
          pc_d    = '0;
          done_d  = 1'b0;
        end
      end
      StRun: begin
        if (!Stall) begin
          if (isHalt) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else if (branchTaken) begin
            pc_d = DestAddr;
          end else begin
            pc_d = pc_q + PC_W'(1);
          end
        end
      end
      StDone: begin
        if (Start) begin
          state_d = StRun;
          pc_d    = '0;
          done_d  = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
        pc_d    = '0;
        done_d  = 1'b0;
      end
    endcase
  end

  // State, program counter and done flag registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= StIdle;
      pc_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      done_q  <= done_d;
    end
  end

`ifdef FETCH_CTRL_CYCLE_CNT_EN
  logic [15:0] cycleCnt_q, cycleCnt_d;

  // Counts every edge spent in RUN, stalled or not; cleared on each start.
  always_comb begin
    cycleCnt_d = cycleCnt_q;
    if (startRun) begin
      cycleCnt_d = '0;
    end else if (state_q == StRun && cycleCnt_q != 16'hFFFF) begin
      cycleCnt_d = cycleCnt_q + 16'd1;
    end
  end

  // Cycle counter register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cycleCnt_q <= '0;
    end else begin
      cycleCnt_q <= cycleCnt_d;
    end
  end

  assign CycleCount = cycleCnt_q;
`else
  assign CycleCount = 16'd0;
`endif

  // Status outputs: run indicators follow the state directly.
  always_comb begin
    ProgCtr   = pc_q;
    Done      = done_q;
    Busy      = (state_q == StRun);
    InstValid = (state_q == StRun);
  end

endmodule
